// File: rtl/aoi_selftest_ctrl.sv
// aoi_selftest_ctrl: self-test sequencer for a switch-level AOI22 cell,
// f = ~((a&b)|(c&d)). Walks {a,b,c,d} through all 16 vectors PASSES times,
// holds each vector SETTLE_CYCLES clocks, samples f_in, and compares it with
// the golden AOI22 function. Mismatches are counted (saturating at 255) and the
// first failing vector is latched.
//
// Optional build macro: AOI_FAILMAP_EN
//   defined   -> fail_map is a sticky per-vector mismatch register
//   undefined -> fail_map is tied to 16'h0000 and no register is built
//
// Handshake: start is a level request with no ready return. It is accepted
// on a rising clk edge only while the controller is idle or done (busy=0).
// While busy=1 it is ignored. The run's results are valid while done=1,
// and they hold until the next accepted start or reset.
//
// Legal parameter range: SETTLE_CYCLES 1..255, PASSES 1..255.

module aoi_selftest_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        f_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [3:0]  first_fail_vec,
  output logic        fail_valid,
  output logic [15:0] fail_map,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

  state_t      state;
  logic [3:0]  vec;
  logic [7:0]  settle_cnt;
  logic [7:0]  pass_idx;
  logic        busy_r;
  logic        done_r;
  logic        pass_r;
  logic [7:0]  err_r;
  logic [3:0]  ffv_r;
  logic        fv_r;

  logic        start_accept;
  logic        exp_f;
  logic        mismatch;
  logic [7:0]  err_next;
  logic        last_vec;
  logic        last_pass;

  // Golden compare and the saturating next error count for the SAMPLE state.
  always_comb begin
    start_accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    exp_f        = ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
    // Case inequality so an unknown cell output counts as a failure.
    mismatch     = (f_in !== exp_f);
    err_next     = err_r;
    if (mismatch && (err_r != 8'hFF)) begin
      err_next = err_r + 8'd1;
    end
    last_vec     = (vec == 4'hF);
    last_pass    = (pass_idx == PASS_LAST);
  end

  // Sequencer FSM: vector walk, settle timing, compare bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec        <= 4'h0;
      settle_cnt <= 8'd0;
      pass_idx   <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      err_r      <= 8'd0;
      ffv_r      <= 4'h0;
      fv_r       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_accept) begin
            state      <= ST_SETTLE;
            vec        <= 4'h0;
            settle_cnt <= 8'd0;
            pass_idx   <= 8'd0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_r      <= 8'd0;
            ffv_r      <= 4'h0;
            fv_r       <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        ST_SAMPLE: begin
          err_r <= err_next;
          if (mismatch && !fv_r) begin
            fv_r  <= 1'b1;
            ffv_r <= vec;
          end
          if (last_vec && last_pass) begin
            // Final sample of the run: park the cell inputs at zero.
            state  <= ST_DONE;
            vec    <= 4'h0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= (err_next == 8'd0);
          end else begin
            state      <= ST_SETTLE;
            settle_cnt <= 8'd0;
            if (last_vec) begin
              vec      <= 4'h0;
              pass_idx <= pass_idx + 8'd1;
            end else begin
              vec <= vec + 4'h1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef AOI_FAILMAP_EN
  logic [15:0] map_r;

  // Sticky record of every vector that ever mismatched in the current run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_r <= 16'h0000;
    end else if (start_accept) begin
      map_r <= 16'h0000;
    end else if ((state == ST_SAMPLE) && mismatch) begin
      map_r[vec] <= 1'b1;
    end
  end

  assign fail_map = map_r;
`else
  assign fail_map = 16'h0000;
`endif

  // vec is held at zero outside a sweep, so the cell inputs idle low.
  assign a              = vec[3];
  assign b              = vec[2];
  assign c              = vec[1];
  assign d              = vec[0];
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_r;
  assign first_fail_vec = ffv_r;
  assign fail_valid     = fv_r;
  assign state_dbg      = state;

endmodule

// File: tb/tb_aoi_selftest_ctrl.sv
// Bench for aoi_selftest_ctrl. Three instances with different SETTLE/PASSES.
// Each cell model is the AOI22 function XOR a per-vector fault mask, so
// stuck-at-0 is mask 16'h0777 and stuck-at-1 is mask 16'hF888.
module tb_aoi_selftest_ctrl;

  localparam int N = 3;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [N-1:0] start_v = '0;
  logic [N-1:0] a_v, b_v, c_v, d_v, f_v;
  logic [N-1:0] busy_v, done_v, pass_v, fv_v;
  logic [7:0]  err_v [N];
  logic [3:0]  ffv_v [N];
  logic [15:0] map_v [N];
  logic [1:0]  st_v  [N];
  logic [15:0] mask_v [N];

  int tests = 0;
  int errs  = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  logic [N-1:0] done_q = '0;

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aoi_selftest_ctrl #(.SETTLE_CYCLES(2), .PASSES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .d(d_v[0]), .f_in(f_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err_v[0]), .first_fail_vec(ffv_v[0]), .fail_valid(fv_v[0]),
    .fail_map(map_v[0]), .state_dbg(st_v[0]));

  aoi_selftest_ctrl #(.SETTLE_CYCLES(1), .PASSES(30)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .d(d_v[1]), .f_in(f_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err_v[1]), .first_fail_vec(ffv_v[1]), .fail_valid(fv_v[1]),
    .fail_map(map_v[1]), .state_dbg(st_v[1]));

  aoi_selftest_ctrl #(.SETTLE_CYCLES(3), .PASSES(20)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .a(a_v[2]), .b(b_v[2]), .c(c_v[2]), .d(d_v[2]), .f_in(f_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_count(err_v[2]), .first_fail_vec(ffv_v[2]), .fail_valid(fv_v[2]),
    .fail_map(map_v[2]), .state_dbg(st_v[2]));

  // cell under test: golden AOI22 with injected per-vector faults
  always_comb begin
    for (int k = 0; k < N; k++) begin
      f_v[k] = ~((a_v[k] & b_v[k]) | (c_v[k] & d_v[k]))
               ^ mask_v[k][{a_v[k], b_v[k], c_v[k], d_v[k]}];
    end
  end

  function automatic int passes_of(input int id);
    return (id == 0) ? 1 : (id == 1) ? 30 : 20;
  endfunction

  function automatic int settle_of(input int id);
    return (id == 0) ? 2 : (id == 1) ? 1 : 3;
  endfunction

  // reference model: whole-run result from the fault mask
  function automatic logic [W-1:0] model(input int id, input logic [15:0] mask);
    int pc = 0;
    int first = -1;
    int total;
    int errc;
    logic [15:0] map;
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) begin
        pc++;
        if (first < 0) first = i;
      end
    end
    total = pc * passes_of(id);
    errc  = (total > 255) ? 255 : total;
`ifdef AOI_FAILMAP_EN
    map = mask;
`else
    map = 16'h0000;
`endif
    return {(total == 0), 8'(errc), (pc != 0), 4'((first < 0) ? 0 : first),
            map, 2'(id)};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs(input int k);
    return {26'd0, a_v[k], b_v[k], c_v[k], d_v[k], busy_v[k], done_v[k],
            pass_v[k], fv_v[k], err_v[k], ffv_v[k], map_v[k], st_v[k]};
  endfunction

  // monitor: on each done rise, pop and compare the expected result
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst_n && done_v[k] && !done_q[k]) begin
        if (exp_q.size() == 0) begin
          tests++;
          errs++;
          $display("FAIL unexpected_done inst=%0d actual=done expected=none", k);
        end else begin
          check("result", 64'({pass_v[k], err_v[k], fv_v[k], ffv_v[k],
                               map_v[k], 2'(k)}), 64'(exp_q.pop_front()));
          check("done_cycle", 64'(cyc), 64'(lat_q.pop_front()));
          check("idle_outputs", 64'({busy_v[k], a_v[k], b_v[k], c_v[k], d_v[k]}), 64'd0);
        end
      end
    end
    done_q <= done_v;
  end

  // driver: set fault mask, pulse start, push the expected response
  task automatic launch(input int id, input logic [15:0] mask);
    mask_v[id] = mask;
    @(posedge clk); #1;
    start_v[id] = 1'b1;
    @(posedge clk); #1;
    start_v[id] = 1'b0;
    exp_q.push_back(model(id, mask));
    lat_q.push_back(cyc + 16 * passes_of(id) * (settle_of(id) + 1));
    check("accept_busy_done", 64'({busy_v[id], done_v[id]}), 64'(2'b10));
  endtask

  task automatic wait_done(input int id);
    int n = 0;
    int budget = 16 * passes_of(id) * (settle_of(id) + 1) + 50;
    while (!done_v[id] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_v[id]) begin
      tests++;
      errs++;
      $display("FAIL done_timeout inst=%0d actual=not_done expected=done", id);
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < N; k++) mask_v[k] = 16'h0000;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) check("reset_values", all_outs(k), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // good cell, stuck-at-0, stuck-at-1 (each restart comes from DONE)
    launch(0, 16'h0000); wait_done(0);
    launch(0, 16'h0777); wait_done(0);
    launch(0, 16'hF888); wait_done(0);

    // random fault patterns
    for (int i = 0; i < 8; i++) begin
      logic [15:0] m;
      m = (i % 2 == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
      launch(0, m);
      wait_done(0);
    end

    // start while busy must be ignored: done timing stays unchanged
    launch(0, 16'($urandom));
    repeat (10) @(posedge clk);
    #1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check("busy_after_ignored_start", 64'(busy_v[0]), 64'd1);
    wait_done(0);

    // reset in the middle of vector 7, then a fresh run
    begin
      int n = 0;
      launch(0, 16'hFFFF);
      while (!({a_v[0], b_v[0], c_v[0], d_v[0]} == 4'h7 && busy_v[0]) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("reached_vec7", 64'({a_v[0], b_v[0], c_v[0], d_v[0], busy_v[0]}), 64'(5'b01111));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_values", all_outs(0), 64'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      if (lat_q.size() > 0) void'(lat_q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      launch(0, 16'h0021);
      wait_done(0);
    end

    // saturation (30 passes) and non-saturated large count (20 passes)
    launch(1, 16'h0777); wait_done(1);
    launch(2, 16'h0777); wait_done(2);
    launch(1, 16'($urandom)); wait_done(1);
    launch(2, 16'h0000); wait_done(2);

    if (exp_q.size() != 0) begin
      tests++;
      errs++;
      $display("FAIL sb_leftover actual=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
